// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package wb_arbiter_pkg;

  localparam int unsigned DEFAULT_XLEN = 64;
  localparam int unsigned REG_ADDR_W   = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // One writeback result as it travels to the register file.
  typedef struct packed {
    logic [REG_ADDR_W-1:0]   addr;
    logic [DEFAULT_XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Synchronous FIFO for buffered MEM writeback results. Each entry is {addr, data}
// with the destination address in the top REG_ADDR_W bits. Also exports
// per-entry valid and address vectors so the pending-write scoreboard can
// see every buffered destination.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = REG_ADDR_W + DEFAULT_XLEN
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              push_i,
  input  logic [Width-1:0]                  push_entry_i,
  input  logic                              pop_i,
  output logic [Width-1:0]                  head_entry_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [Depth-1:0]                  entry_valid_o,
  output logic [Depth-1:0][REG_ADDR_W-1:0]  entry_addr_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [PtrW:0]    count_q, count_d;
  logic [Depth-1:0] valid_q, valid_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];

  logic do_pop;

  assign full_o       = (count_q == (PtrW + 1)'(Depth));
  assign empty_o      = (count_q == '0);
  assign do_pop       = pop_i && !empty_o;
  assign head_entry_o = mem_q[head_q];

  // Pointer, count and valid-flag update; pop clears before push sets so a
  // simultaneous push/pop on a full FIFO keeps the recycled slot valid.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    mem_d   = mem_q;
    if (do_pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push_i) begin
      valid_d[tail_q] = 1'b1;
      mem_d[tail_q]   = push_entry_i;
      tail_d          = tail_q + 1'b1;
    end
    if (push_i && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_i && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry storage; contents are meaningless unless the matching valid bit is set.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Expose buffered destinations for the busy compare.
  always_comb begin
    entry_valid_o = valid_q;
    for (int i = 0; i < Depth; i++) begin
      entry_addr_o[i] = mem_q[i][Width-1 -: REG_ADDR_W];
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: merges single-cycle ALU results and buffered
// MEM results into one registered write port and exports per-source busy flags.
// Optional feature macro: WB_ARBITER_BYPASS_EN adds output-stage forwarding ports.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned XLEN      = DEFAULT_XLEN,
  parameter int unsigned MEM_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  aluValid,
  output logic                  aluReady,
  input  logic [REG_ADDR_W-1:0] aluAddr,
  input  logic [XLEN-1:0]       aluData,
  input  logic                  memValid,
  output logic                  memReady,
  input  logic [REG_ADDR_W-1:0] memAddr,
  input  logic [XLEN-1:0]       memData,
  output logic                  wen,
  output logic [REG_ADDR_W-1:0] wAddr,
  output logic [XLEN-1:0]       wData,
  input  logic [REG_ADDR_W-1:0] rs1Addr,
  input  logic [REG_ADDR_W-1:0] rs2Addr,
`ifdef WB_ARBITER_BYPASS_EN
  output logic                  rs1FwdValid,
  output logic [XLEN-1:0]       rs1FwdData,
  output logic                  rs2FwdValid,
  output logic [XLEN-1:0]       rs2FwdData,
`endif
  output logic                  rs1Busy,
  output logic                  rs2Busy
);

  localparam int unsigned EntryW = REG_ADDR_W + XLEN;

  logic                                 fifo_full, fifo_empty, fifo_push, pop_sel, alu_sel;
  logic [EntryW-1:0]                    head_entry;
  logic [MEM_DEPTH-1:0]                 entry_valid;
  logic [MEM_DEPTH-1:0][REG_ADDR_W-1:0] entry_addr;

  logic                  wen_q, wen_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;

  logic fifo_hit1, fifo_hit2, out_hit1, out_hit2;

  wb_fifo #(
    .Depth (MEM_DEPTH),
    .Width (EntryW)
  ) u_mem_fifo (
    .clock         (clock),
    .reset         (reset),
    .push_i        (fifo_push),
    .push_entry_i  ({memAddr, memData}),
    .pop_i         (pop_sel),
    .head_entry_o  (head_entry),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .entry_valid_o (entry_valid),
    .entry_addr_o  (entry_addr)
  );

  // Arbitration: FIFO drains whenever full or the ALU is idle; otherwise ALU wins.
  always_comb begin
    pop_sel   = !fifo_empty && (fifo_full || !aluValid);
    alu_sel   = !pop_sel && aluValid;
    aluReady  = alu_sel;
    memReady  = !fifo_full || pop_sel;
    fifo_push = memValid && memReady;
  end

  // Next write-port value; address/data hold when nothing is selected.
  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (pop_sel) begin
      waddr_d = head_entry[EntryW-1 -: REG_ADDR_W];
      wdata_d = head_entry[XLEN-1:0];
      wen_d   = (waddr_d != ZERO_REG);
    end else if (alu_sel) begin
      waddr_d = aluAddr;
      wdata_d = aluData;
      wen_d   = (aluAddr != ZERO_REG);
    end
  end

  // Registered write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign wen   = wen_q;
  assign wAddr = waddr_q;
  assign wData = wdata_q;

  // Pending-write scoreboard: FIFO entries plus the output stage.
  always_comb begin
    fifo_hit1 = 1'b0;
    fifo_hit2 = 1'b0;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      fifo_hit1 = fifo_hit1 | (entry_valid[i] && entry_addr[i] == rs1Addr);
      fifo_hit2 = fifo_hit2 | (entry_valid[i] && entry_addr[i] == rs2Addr);
    end
    out_hit1 = wen_q && (waddr_q == rs1Addr) && (rs1Addr != ZERO_REG);
    out_hit2 = wen_q && (waddr_q == rs2Addr) && (rs2Addr != ZERO_REG);
`ifdef WB_ARBITER_BYPASS_EN
    // Output-stage matches are forwarded instead of stalling.
    rs1Busy = (rs1Addr != ZERO_REG) && fifo_hit1;
    rs2Busy = (rs2Addr != ZERO_REG) && fifo_hit2;
`else
    rs1Busy = (rs1Addr != ZERO_REG) && (fifo_hit1 || out_hit1);
    rs2Busy = (rs2Addr != ZERO_REG) && (fifo_hit2 || out_hit2);
`endif
  end

`ifdef WB_ARBITER_BYPASS_EN
  assign rs1FwdValid = out_hit1;
  assign rs2FwdValid = out_hit2;
  assign rs1FwdData  = wdata_q;
  assign rs2FwdData  = wdata_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default build; bypass checks are
// compiled in only when WB_ARBITER_BYPASS_EN is defined).
module tb_wb_arbiter;

  localparam int unsigned XLEN = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic            aluValid, memValid;
  logic            aluReady, memReady;
  logic [4:0]      aluAddr, memAddr, rs1Addr, rs2Addr;
  logic [XLEN-1:0] aluData, memData;
  logic            wen;
  logic [4:0]      wAddr;
  logic [XLEN-1:0] wData;
  logic            rs1Busy, rs2Busy;
`ifdef WB_ARBITER_BYPASS_EN
  logic            rs1FwdValid, rs2FwdValid;
  logic [XLEN-1:0] rs1FwdData, rs2FwdData;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  wb_arbiter #(
    .XLEN      (XLEN),
    .MEM_DEPTH (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .aluValid (aluValid),
    .aluReady (aluReady),
    .aluAddr  (aluAddr),
    .aluData  (aluData),
    .memValid (memValid),
    .memReady (memReady),
    .memAddr  (memAddr),
    .memData  (memData),
    .wen      (wen),
    .wAddr    (wAddr),
    .wData    (wData),
    .rs1Addr  (rs1Addr),
    .rs2Addr  (rs2Addr),
`ifdef WB_ARBITER_BYPASS_EN
    .rs1FwdValid (rs1FwdValid),
    .rs1FwdData  (rs1FwdData),
    .rs2FwdValid (rs2FwdValid),
    .rs2FwdData  (rs2FwdData),
`endif
    .rs1Busy  (rs1Busy),
    .rs2Busy  (rs2Busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic e, input logic [4:0] a,
                        input logic [63:0] d);
    chk({tag, ".wen"}, 64'(wen), 64'(e));
    chk({tag, ".wAddr"}, 64'(wAddr), 64'(a));
    chk({tag, ".wData"}, wData, d);
  endtask

  initial begin
    reset = 1'b1; aluValid = 1'b0; memValid = 1'b0;
    aluAddr = '0; aluData = '0; memAddr = '0; memData = '0;
    rs1Addr = '0; rs2Addr = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk_wr("reset", 1'b0, 5'd0, 64'h0);
    chk("reset.memReady", 64'(memReady), 64'd1);
    chk("reset.aluReady", 64'(aluReady), 64'd0);

    // ALU only
    tick();
    aluValid = 1'b1; aluAddr = 5'd5; aluData = 64'h1234; rs1Addr = 5'd5;
    #1;
    chk("alu.aluReady", 64'(aluReady), 64'd1);
    chk("alu.busy_pre", 64'(rs1Busy), 64'd0);
    tick();
    aluValid = 1'b0;
    #1;
    chk_wr("alu.write", 1'b1, 5'd5, 64'h1234);
    chk("alu.rs1Busy", 64'(rs1Busy), 64'd1);
    tick();
    chk("alu.wen_drop", 64'(wen), 64'd0);
    chk("alu.busy_drop", 64'(rs1Busy), 64'd0);

    // MEM only: two consecutive pushes
    memValid = 1'b1; memAddr = 5'd7; memData = 64'hAA;
    #1;
    chk("mem.ready0", 64'(memReady), 64'd1);
    tick();
    memAddr = 5'd8; memData = 64'hBB; rs2Addr = 5'd7;
    #1;
    chk("mem.ready1", 64'(memReady), 64'd1);
    chk("mem.wen_early", 64'(wen), 64'd0);
    chk("mem.busy7", 64'(rs2Busy), 64'd1);
    tick();
    memValid = 1'b0;
    #1;
    chk_wr("mem.write7", 1'b1, 5'd7, 64'hAA);
    chk("mem.ready2", 64'(memReady), 64'd1);
    tick();
    chk_wr("mem.write8", 1'b1, 5'd8, 64'hBB);
    rs2Addr = 5'd8;
    #1;
    chk("mem.busy8_out", 64'(rs2Busy), 64'd1);
    tick();
    chk("mem.done_wen", 64'(wen), 64'd0);
    chk("mem.busy8_clear", 64'(rs2Busy), 64'd0);

    // Contention: ALU held on r3 while MEM pushes r10..r13, then r14 on full
    aluValid = 1'b1; aluAddr = 5'd3; aluData = 64'h33;
    for (int i = 0; i < 4; i++) begin
      memValid = 1'b1; memAddr = 5'(10 + i); memData = 64'hA0 + 64'(i);
      #1;
      chk($sformatf("cont.aluReady%0d", i), 64'(aluReady), 64'd1);
      chk($sformatf("cont.memReady%0d", i), 64'(memReady), 64'd1);
      tick();
      chk_wr($sformatf("cont.alu_wr%0d", i), 1'b1, 5'd3, 64'h33);
    end
    memAddr = 5'd14; memData = 64'hA4;
    #1;
    chk("cont.full_aluReady", 64'(aluReady), 64'd0);
    chk("cont.full_memReady", 64'(memReady), 64'd1);
    tick();
    memValid = 1'b0; rs1Addr = 5'd14;
    chk_wr("cont.pop10", 1'b1, 5'd10, 64'hA0);
    #1;
    chk("cont.still_full_aluReady", 64'(aluReady), 64'd0);
    chk("cont.busy14", 64'(rs1Busy), 64'd1);
    tick();
    chk_wr("cont.pop11", 1'b1, 5'd11, 64'hA1);
    #1;
    chk("cont.alu_again", 64'(aluReady), 64'd1);
    tick();
    aluValid = 1'b0;
    chk_wr("cont.alu_wr4", 1'b1, 5'd3, 64'h33);
    tick();
    chk_wr("cont.pop12", 1'b1, 5'd12, 64'hA2);
    tick();
    chk_wr("cont.pop13", 1'b1, 5'd13, 64'hA3);
    tick();
    chk_wr("cont.pop14", 1'b1, 5'd14, 64'hA4);
    tick();
    chk("cont.drained", 64'(wen), 64'd0);
    chk("cont.busy14_clear", 64'(rs1Busy), 64'd0);

    // x0 destination
    aluValid = 1'b1; aluAddr = 5'd0; aluData = 64'hFF; rs1Addr = 5'd0;
    #1;
    chk("x0.aluReady", 64'(aluReady), 64'd1);
    tick();
    aluValid = 1'b0;
    #1;
    chk_wr("x0.write", 1'b0, 5'd0, 64'hFF);
    chk("x0.rs1Busy", 64'(rs1Busy), 64'd0);

    // Reset mid-stream with three buffered MEM entries
    tick();
    aluValid = 1'b1; aluAddr = 5'd4; aluData = 64'h44;
    for (int i = 0; i < 3; i++) begin
      memValid = 1'b1; memAddr = 5'(20 + i); memData = 64'hC0 + 64'(i);
      tick();
    end
    memValid = 1'b0; aluValid = 1'b0; rs1Addr = 5'd20; rs2Addr = 5'd4;
    #1;
    chk("rst.busy_fifo_pre", 64'(rs1Busy), 64'd1);
    chk("rst.busy_out_pre", 64'(rs2Busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk_wr("rst.after", 1'b0, 5'd0, 64'h0);
    chk("rst.rs1Busy", 64'(rs1Busy), 64'd0);
    chk("rst.rs2Busy", 64'(rs2Busy), 64'd0);
    chk("rst.memReady", 64'(memReady), 64'd1);
    tick();
    chk("rst.no_write1", 64'(wen), 64'd0);
    tick();
    chk("rst.no_write2", 64'(wen), 64'd0);

`ifdef WB_ARBITER_BYPASS_EN
    aluValid = 1'b1; aluAddr = 5'd9; aluData = 64'h55; rs2Addr = 5'd9;
    tick();
    aluValid = 1'b0;
    #1;
    chk("byp.fwdValid", 64'(rs2FwdValid), 64'd1);
    chk("byp.fwdData", rs2FwdData, 64'h55);
    chk("byp.rs2Busy", 64'(rs2Busy), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
